// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 constants: register numbers, exception codes, writable-field masks.
package cp0_regfile_pkg;

    // CP0 register numbers (rd field of MFC0/MTC0)
    localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_REG_EPC      = 5'd14;

    // Exception type codes as delivered by the exception decoder
    localparam logic [31:0] EXC_INT  = 32'h0000_0000;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;
    localparam logic [31:0] EXC_NONE = 32'hffff_ffff;

    // Software-writable fields: Status IM[15:8]/EXL[1]/IE[0], Cause IP[1:0]
    localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    // True for codes that enter the exception vector (set EXL, record EPC/ExcCode)
    function automatic logic exc_is_fault(input logic [31:0] t);
        return (t == EXC_INT) || (t == EXC_ADEL) || (t == EXC_ADES) ||
               (t == EXC_SYS) || (t == EXC_BP)   || (t == EXC_RI)   ||
               (t == EXC_OV);
    endfunction

    // Replace the masked bits of old_v with those of new_v
    function automatic logic [31:0] merge_masked(input logic [31:0] old_v,
                                                 input logic [31:0] new_v,
                                                 input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

endpackage

// File: rtl/cp0_regfile_timer.sv
// CP0 Count/Compare timer: prescaled Count, Compare register and the
// sticky timer interrupt that only a Compare write (or reset) clears.
module cp0_regfile_timer #(
    parameter int CNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we_count,
    input  logic        i_we_compare,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_timer_int
);

    localparam int              DIV_W    = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CNT_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic [31:0]      r_count;
    logic [31:0]      r_compare;
    logic             r_timer_int;
    logic             w_wrap;
    logic             w_hit;

    assign w_wrap = (r_div == DIV_LAST);
    assign w_hit  = (r_count == r_compare) && (r_compare != 32'd0);

    // Count prescaler; a software Count write restarts the prescale period
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div   <= '0;
            r_count <= 32'd0;
        end else if (i_we_count) begin
            r_div   <= '0;
            r_count <= i_wdata;
        end else if (w_wrap) begin
            r_div   <= '0;
            r_count <= r_count + 32'd1;
        end else begin
            r_div   <= r_div + DIV_W'(1);
        end
    end

    // Compare register and sticky match flag; writing Compare acknowledges it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_compare   <= 32'd0;
            r_timer_int <= 1'b0;
        end else if (i_we_compare) begin
            r_compare   <= i_wdata;
            r_timer_int <= 1'b0;
        end else if (w_hit) begin
            r_timer_int <= 1'b1;
        end
    end

    assign o_count     = r_count;
    assign o_compare   = r_compare;
    assign o_timer_int = r_timer_int;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: Status/Cause/EPC/BadVAddr, exception commit from MEM,
// MFC0 read port with MTC0 bypass, and the Count/Compare timer.
module cp0_regfile
    import cp0_regfile_pkg::*;
#(
    parameter logic [31:0] STATUS_RST = 32'h0040_0000,
    parameter int          CNT_DIV    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    input  logic [5:0]  int_i,
    input  logic [31:0] except_type_i,
    input  logic [31:0] pc_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic [31:0] r_status;
    logic [31:0] r_cause;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;

    logic        w_exc;
    logic        w_fault;
    logic        w_eret;
    logic        w_addr_exc;
    logic        w_mtc0;
    logic        w_timer_int;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic [31:0] w_status_wr;
    logic [31:0] w_cause_wr;
    logic [5:0]  w_ip_hw;
    logic [31:0] w_cur;
    logic [31:0] w_post;

    // A committing exception squashes the MTC0 of the faulting instruction
    assign w_exc       = (except_type_i != EXC_NONE);
    assign w_fault     = exc_is_fault(except_type_i);
    assign w_eret      = (except_type_i == EXC_ERET);
    assign w_addr_exc  = (except_type_i == EXC_ADEL) || (except_type_i == EXC_ADES);
    assign w_mtc0      = we_i && !w_exc;

    assign w_status_wr = merge_masked(r_status, wdata_i, STATUS_WMASK);
    assign w_cause_wr  = merge_masked(r_cause, wdata_i, CAUSE_WMASK);
    assign w_ip_hw     = {int_i[5] | w_timer_int, int_i[4:0]};

    cp0_regfile_timer #(
        .CNT_DIV (CNT_DIV)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .i_we_count   (w_mtc0 && (waddr_i == CP0_REG_COUNT)),
        .i_we_compare (w_mtc0 && (waddr_i == CP0_REG_COMPARE)),
        .i_wdata      (wdata_i),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_timer_int  (w_timer_int)
    );

    // Status: exceptions set EXL, ERET clears it, MTC0 updates IM/EXL/IE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_status <= STATUS_RST;
        end else if (w_fault) begin
            r_status[1] <= 1'b1;
        end else if (w_eret) begin
            r_status[1] <= 1'b0;
        end else if (w_mtc0 && (waddr_i == CP0_REG_STATUS)) begin
            r_status <= w_status_wr;
        end
    end

    // Cause: hardware IP sampled every cycle; ExcCode/BD on exception; IP[1:0] by MTC0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cause <= 32'd0;
        end else begin
            r_cause[15:10] <= w_ip_hw;
            if (w_fault) begin
                r_cause[6:2] <= except_type_i[4:0];
                if (!r_status[1]) begin
                    r_cause[31] <= is_in_delayslot_i;
                end
            end else if (w_mtc0 && (waddr_i == CP0_REG_CAUSE)) begin
                r_cause[9:8] <= wdata_i[9:8];
            end
        end
    end

    // EPC: captured on first-level exception (branch address for delay slots)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_epc <= 32'd0;
        end else if (w_fault) begin
            if (!r_status[1]) begin
                r_epc <= is_in_delayslot_i ? (pc_i - 32'd4) : pc_i;
            end
        end else if (w_mtc0 && (waddr_i == CP0_REG_EPC)) begin
            r_epc <= wdata_i;
        end
    end

    // BadVAddr: loaded only by address-error exceptions, read-only to software
    always_ff @(posedge clk) begin
        if (rst) begin
            r_badvaddr <= 32'd0;
        end else if (w_fault && w_addr_exc) begin
            r_badvaddr <= bad_addr_i;
        end
    end

    // MFC0 read: current register, or the post-write value when MTC0 targets it
    always_comb begin
        w_cur = 32'd0;
        case (raddr_i)
            CP0_REG_BADVADDR: w_cur = r_badvaddr;
            CP0_REG_COUNT:    w_cur = w_count;
            CP0_REG_COMPARE:  w_cur = w_compare;
            CP0_REG_STATUS:   w_cur = r_status;
            CP0_REG_CAUSE:    w_cur = r_cause;
            CP0_REG_EPC:      w_cur = r_epc;
            default:          w_cur = 32'd0;
        endcase
        w_post = w_cur;
        case (raddr_i)
            CP0_REG_COUNT:   w_post = wdata_i;
            CP0_REG_COMPARE: w_post = wdata_i;
            CP0_REG_STATUS:  w_post = w_status_wr;
            CP0_REG_CAUSE:   w_post = w_cause_wr;
            CP0_REG_EPC:     w_post = wdata_i;
            default:         w_post = w_cur;
        endcase
        rdata_o = (w_mtc0 && (waddr_i == raddr_i)) ? w_post : w_cur;
    end

    assign status_o    = r_status;
    assign cause_o     = r_cause;
    assign epc_o       = r_epc;
    assign badvaddr_o  = r_badvaddr;
    assign count_o     = w_count;
    assign compare_o   = w_compare;
    assign timer_int_o = w_timer_int;

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed scenarios followed by random
// MTC0/MFC0/exception/interrupt traffic against a behavioural register model.
module tb_cp0_regfile;

    localparam int          CNT_DIV    = 2;
    localparam logic [31:0] STATUS_RST = 32'h0040_0000;
    localparam logic [31:0] NONE       = 32'hffff_ffff;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic [5:0]  int_i;
    logic [31:0] except_type_i;
    logic [31:0] pc_i;
    logic        is_in_delayslot_i;
    logic [31:0] bad_addr_i;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic [31:0] badvaddr_o;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic        timer_int_o;

    cp0_regfile #(
        .STATUS_RST (STATUS_RST),
        .CNT_DIV    (CNT_DIV)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .we_i              (we_i),
        .waddr_i           (waddr_i),
        .wdata_i           (wdata_i),
        .raddr_i           (raddr_i),
        .rdata_o           (rdata_o),
        .int_i             (int_i),
        .except_type_i     (except_type_i),
        .pc_i              (pc_i),
        .is_in_delayslot_i (is_in_delayslot_i),
        .bad_addr_i        (bad_addr_i),
        .status_o          (status_o),
        .cause_o           (cause_o),
        .epc_o             (epc_o),
        .badvaddr_o        (badvaddr_o),
        .count_o           (count_o),
        .compare_o         (compare_o),
        .timer_int_o       (timer_int_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] seen_rdata;

    // Reference model state
    logic [31:0] m_status, m_cause, m_epc, m_badv, m_count, m_compare;
    logic        m_timer;
    int          m_ticks;   // cycles since the last Count increment or write

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_reg(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_read();
        if (we_i && (waddr_i == raddr_i) && (except_type_i == NONE)) begin
            case (raddr_i)
                5'd9, 5'd11, 5'd14: return wdata_i;
                5'd12: return (STATUS_RST & ~32'h0000_ff03) | (wdata_i & 32'h0000_ff03);
                5'd13: return (m_cause & ~32'h0000_0300) | (wdata_i & 32'h0000_0300);
                default: return model_reg(raddr_i);
            endcase
        end
        return model_reg(raddr_i);
    endfunction

    // One clock edge of the architectural rules, using the values before the edge
    task automatic model_edge();
        logic        fault, mt, old_exl, old_timer;
        logic [31:0] old_count, old_compare;
        if (rst) begin
            m_status = STATUS_RST; m_cause = 0; m_epc = 0; m_badv = 0;
            m_count = 0; m_compare = 0; m_timer = 0; m_ticks = 0;
            return;
        end
        fault       = except_type_i inside {32'h0, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc};
        mt          = we_i && (except_type_i == NONE);
        old_exl     = m_status[1];
        old_timer   = m_timer;
        old_count   = m_count;
        old_compare = m_compare;

        m_cause[15:10] = {int_i[5] | old_timer, int_i[4:0]};

        if (mt && waddr_i == 5'd9) begin
            m_count = wdata_i; m_ticks = 0;
        end else begin
            m_ticks++;
            if (m_ticks == CNT_DIV) begin
                m_count = old_count + 1; m_ticks = 0;
            end
        end
        if (mt && waddr_i == 5'd11) begin
            m_compare = wdata_i; m_timer = 0;
        end else if (old_count == old_compare && old_compare != 0) begin
            m_timer = 1;
        end

        if (fault) begin
            m_cause[6:2] = except_type_i[4:0];
            if (!old_exl) begin
                m_epc       = is_in_delayslot_i ? pc_i - 32'd4 : pc_i;
                m_cause[31] = is_in_delayslot_i;
            end
            m_status[1] = 1'b1;
            if (except_type_i == 32'h4 || except_type_i == 32'h5) m_badv = bad_addr_i;
        end else if (except_type_i == 32'he) begin
            m_status[1] = 1'b0;
        end else if (mt) begin
            case (waddr_i)
                5'd12: m_status = (STATUS_RST & ~32'h0000_ff03) | (wdata_i & 32'h0000_ff03);
                5'd13: m_cause[9:8] = wdata_i[9:8];
                5'd14: m_epc = wdata_i;
                default: ;
            endcase
        end
    endtask

    task automatic check_outputs();
        check("status", status_o, m_status);
        check("cause", cause_o, m_cause);
        check("epc", epc_o, m_epc);
        check("badvaddr", badvaddr_o, m_badv);
        check("count", count_o, m_count);
        check("compare", compare_o, m_compare);
        check("timer_int", {31'd0, timer_int_o}, {31'd0, m_timer});
    endtask

    // Driver: called at a negedge; applies inputs, checks MFC0, clocks, checks state
    task automatic drive_cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [4:0] ra, input logic [5:0] intr,
                               input logic [31:0] et, input logic [31:0] pc,
                               input logic ds, input logic [31:0] ba);
        we_i = we; waddr_i = wa; wdata_i = wd; raddr_i = ra; int_i = intr;
        except_type_i = et; pc_i = pc; is_in_delayslot_i = ds; bad_addr_i = ba;
        #1;
        seen_rdata = rdata_o;
        if (!rst) check("rdata", rdata_o, model_read());
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        drive_cycle(1'b0, 5'd0, 32'd0, 5'd9, 6'd0, NONE, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic mtc0(input logic [4:0] wa, input logic [31:0] wd);
        drive_cycle(1'b1, wa, wd, 5'd0, 6'd0, NONE, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic commit(input logic [31:0] et, input logic [31:0] pc, input logic ds,
                          input logic [31:0] ba);
        drive_cycle(1'b0, 5'd0, 32'd0, 5'd14, 6'd0, et, pc, ds, ba);
    endtask

    initial begin : main
        logic [4:0]  regs [7];
        logic [31:0] codes [10];
        logic [31:0] et;
        logic [4:0]  wa, ra;
        logic [31:0] wd;
        regs  = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
        codes = '{32'h0, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc, 32'he, 32'h3, 32'h1f};

        rst = 1'b1;
        @(negedge clk);
        idle();
        idle();
        rst = 1'b0;

        // Reset values and prescaled Count after 10 idle cycles
        for (int i = 0; i < 10; i++) idle();
        check("t1_status", status_o, 32'h0040_0000);
        check("t1_count", count_o, 32'd5);
        check("t1_cause", cause_o, 32'd0);

        // Timer match raises timer_int and Cause.IP7; Compare write clears it
        mtc0(5'd11, 32'd8);
        mtc0(5'd9, 32'd0);
        for (int i = 0; i < 40 && !timer_int_o; i++) idle();
        check("t2_irq", {31'd0, timer_int_o}, 32'd1);
        check("t2_count_at_irq", count_o, 32'd8);
        idle();
        check("t2_ip7", {31'd0, cause_o[15]}, 32'd1);
        mtc0(5'd11, 32'h20);
        check("t2_irq_clr", {31'd0, timer_int_o}, 32'd0);

        // Syscall then ERET
        commit(32'h8, 32'hbfc0_0100, 1'b0, 32'd0);
        check("t3_epc", epc_o, 32'hbfc0_0100);
        check("t3_exccode", {27'd0, cause_o[6:2]}, 32'h8);
        check("t3_exl", {31'd0, status_o[1]}, 32'd1);
        check("t3_bd", {31'd0, cause_o[31]}, 32'd0);
        commit(32'he, 32'hdead_0000, 1'b0, 32'd0);
        check("t3_eret_exl", {31'd0, status_o[1]}, 32'd0);
        check("t3_eret_epc", epc_o, 32'hbfc0_0100);

        // AdEL in a delay slot, then a nested AdES with EXL already set
        commit(32'h4, 32'hbfc0_0200, 1'b1, 32'h0000_0003);
        check("t4_epc", epc_o, 32'hbfc0_01fc);
        check("t4_bd", {31'd0, cause_o[31]}, 32'd1);
        check("t4_badv", badvaddr_o, 32'h0000_0003);
        commit(32'h5, 32'hbfc0_0300, 1'b0, 32'h0000_0007);
        check("t4_nested_epc", epc_o, 32'hbfc0_01fc);
        check("t4_nested_exccode", {27'd0, cause_o[6:2]}, 32'h5);
        check("t4_nested_bd", {31'd0, cause_o[31]}, 32'd1);
        commit(32'he, 32'd0, 1'b0, 32'd0);

        // Status write mask; exception squashes a same-cycle MTC0
        mtc0(5'd12, 32'hffff_ffff);
        check("t5_status_mask", status_o, 32'h0040_ff03);
        mtc0(5'd12, 32'h0000_ff00);
        drive_cycle(1'b1, 5'd14, 32'h0000_1234, 5'd14, 6'd0, 32'hc, 32'hbfc0_0400, 1'b0, 32'd0);
        check("t5_mtc0_dropped", epc_o, 32'hbfc0_0400);
        commit(32'he, 32'd0, 1'b0, 32'd0);

        // MFC0 bypass of a same-cycle MTC0, and hardware interrupt sampling
        drive_cycle(1'b1, 5'd14, 32'ha5a5_a5a5, 5'd14, 6'd0, NONE, 32'd0, 1'b0, 32'd0);
        check("t6_bypass", seen_rdata, 32'ha5a5_a5a5);
        drive_cycle(1'b0, 5'd0, 32'd0, 5'd13, 6'b000001, NONE, 32'd0, 1'b0, 32'd0);
        check("t6_ip2", {31'd0, cause_o[10]}, 32'd1);

        // Random traffic with occasional mid-run resets
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            et  = ($urandom_range(0, 3) == 0) ? codes[$urandom_range(0, 9)] : NONE;
            wa  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : regs[$urandom_range(0, 6)];
            ra  = ($urandom_range(0, 2) == 0) ? wa : regs[$urandom_range(0, 6)];
            wd  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            drive_cycle(1'($urandom_range(0, 9) < 4), wa, wd, ra, 6'($urandom),
                        et, $urandom, 1'($urandom), $urandom);
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
